// File: rtl/pio_pkg.sv
// Action codes shared by the PIO block, its command sequencer and the benches,
// plus the sequencer FSM state encoding.
package pio_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_INSTR = 4'd1;
    localparam logic [3:0] OP_PEND  = 4'd2;
    localparam logic [3:0] OP_PULL  = 4'd3;
    localparam logic [3:0] OP_PUSH  = 4'd4;
    localparam logic [3:0] OP_GRPS  = 4'd5;
    localparam logic [3:0] OP_EN    = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_SIDES = 4'd8;
    localparam logic [3:0] OP_IMM   = 4'd9;
    localparam logic [3:0] OP_SHIFT = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_HOLD,
        ST_CAPT,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/pio_cmd_seq.sv
// Turns host commands into timed PIO bus actions, one command in flight, one response each.
// PUSH/PULL stall on the target FIFO flag up to WAIT_MAX cycles; cmd_ready only in IDLE.
module pio_cmd_seq
    import pio_pkg::*;
#(
    parameter int IMM_HOLD = 3,
    parameter int WAIT_MAX = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [1:0]  cmd_mindex,
    input  logic [4:0]  cmd_index,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [5:0]  action,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    output logic [31:0] din,
    input  logic [31:0] dout,
    input  logic [3:0]  tx_full,
    input  logic [3:0]  rx_empty
);

    seq_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_inc;
    logic        err_d, gate, accept;
    logic [3:0]  iss_op;
    logic [4:0]  iss_index;
    logic [1:0]  iss_mindex;
    logic [31:0] iss_data;

    logic [3:0]  cmd_op_q;
    logic [1:0]  cmd_mindex_q;
    logic [4:0]  cmd_index_q;
    logic [31:0] cmd_data_q;

    logic        cmd_ready_q, rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_data_q, din_q;
    logic [5:0]  action_q;
    logic [4:0]  index_q;
    logic [1:0]  mindex_q;

    assign accept     = cmd_valid && cmd_ready_q;
    assign cnt_inc    = {1'b0, cnt_q} + 17'd1;
    assign gate       = (cmd_op_q == OP_PUSH) ? tx_full[cmd_mindex_q] : rx_empty[cmd_mindex_q];

    // A command leaving IDLE straight into ISSUE is not latched yet, so take it from the port.
    assign iss_op     = (state_q == ST_IDLE) ? cmd_op     : cmd_op_q;
    assign iss_index  = (state_q == ST_IDLE) ? cmd_index  : cmd_index_q;
    assign iss_mindex = (state_q == ST_IDLE) ? cmd_mindex : cmd_mindex_q;
    assign iss_data   = (state_q == ST_IDLE) ? cmd_data   : cmd_data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (cmd_op > OP_SHIFT) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (cmd_op == OP_NONE) begin
                        state_d = ST_RESP;
                    end else if (cmd_op == OP_PUSH || cmd_op == OP_PULL) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_WAIT: begin
                if (!gate) begin
                    state_d = ST_ISSUE;
                end else if (cnt_inc >= 17'(WAIT_MAX)) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            ST_ISSUE: begin
                // The counter tracks bus cycles already spent, ISSUE being the first.
                if (cmd_op_q == OP_IMM && IMM_HOLD > 1) begin
                    state_d = ST_HOLD;
                    cnt_d   = 16'd1;
                end else if (cmd_op_q == OP_PULL) begin
                    state_d = ST_CAPT;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_HOLD: begin
                if (cnt_inc >= 17'(IMM_HOLD)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            ST_CAPT: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_op_q     <= OP_NONE;
            cmd_mindex_q <= '0;
            cmd_index_q  <= '0;
            cmd_data_q   <= '0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            action_q     <= '0;
            index_q      <= '0;
            mindex_q     <= '0;
            din_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_err_q   <= err_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            if (accept) begin
                cmd_op_q     <= cmd_op;
                cmd_mindex_q <= cmd_mindex;
                cmd_index_q  <= cmd_index;
                cmd_data_q   <= cmd_data;
                rsp_data_q   <= '0;
            end
            if (state_q == ST_CAPT) begin
                rsp_data_q <= dout;
            end
            action_q <= (state_d == ST_ISSUE || state_d == ST_HOLD) ? {2'b00, iss_op} : 6'd0;
            if (state_d == ST_ISSUE) begin
                index_q  <= iss_index;
                mindex_q <= iss_mindex;
                din_q    <= iss_data;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign action    = action_q;
    assign index     = index_q;
    assign mindex    = mindex_q;
    assign din       = din_q;

endmodule

// File: tb/tb_pio_cmd_seq.sv
// Directed bench for pio_cmd_seq: a default instance for the main flow and a
// WAIT_MAX=16 instance for the stall timeout; responses are scoreboarded.
module tb_pio_cmd_seq;
    import pio_pkg::*;

    logic        clk, reset_n;
    logic        cmd_valid, cmd_ready, cmd_valid_b, cmd_ready_b;
    logic [3:0]  cmd_op;
    logic [1:0]  cmd_mindex;
    logic [4:0]  cmd_index;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_data_b;
    logic [5:0]  action, action_b;
    logic [4:0]  index, index_b;
    logic [1:0]  mindex, mindex_b;
    logic [31:0] din, din_b, dout;
    logic [3:0]  tx_full, rx_empty;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    pio_cmd_seq #(.IMM_HOLD(3), .WAIT_MAX(1024)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mindex(cmd_mindex), .cmd_index(cmd_index), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .action(action), .index(index), .mindex(mindex), .din(din),
        .dout(dout), .tx_full(tx_full), .rx_empty(rx_empty)
    );

    pio_cmd_seq #(.IMM_HOLD(3), .WAIT_MAX(16)) u_dut_to (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op),
        .cmd_mindex(cmd_mindex), .cmd_index(cmd_index), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .action(action_b), .index(index_b), .mindex(mindex_b), .din(din_b),
        .dout(dout), .tx_full(tx_full), .rx_empty(rx_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare a response that is on the bus in the current cycle against the scoreboard head.
    task automatic pop_chk(input string tag, input logic v, input logic [31:0] d, input logic e);
        logic [32:0] exp;
        chk({tag, "_vld"}, 32'(v), 32'd1);
        chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_data"}, d, exp[31:0]);
            chk({tag, "_err"}, 32'(e), 32'(exp[32]));
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        pop_chk(tag, rsp_valid, rsp_data, rsp_err);
        tick();
    endtask

    // Drives one command on the main instance; returns in the cycle after acceptance.
    task automatic send(input logic [3:0] op, input logic [1:0] mi, input logic [4:0] ix,
                        input logic [31:0] d, input logic want, input logic [32:0] exp);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_mindex = mi;
        cmd_index  = ix;
        cmd_data   = d;
        if (want) exp_q.push_back(exp);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_valid_b = 1'b0;
        cmd_op = '0; cmd_mindex = '0; cmd_index = '0; cmd_data = '0;
        rsp_ready = 1'b1; dout = '0; tx_full = '0; rx_empty = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        chk("rst_action", 32'(action), 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_index_mindex", {25'd0, index, mindex}, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_err, 30'd0}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // GRPS: one bus cycle, response the cycle after.
        send(OP_GRPS, 2'd0, 5'd0, 32'h4000_0000, 1'b1, {1'b0, 32'd0});
        chk("grps_action", 32'(action), 32'd5);
        chk("grps_din", din, 32'h4000_0000);
        chk("grps_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("grps_action_off", 32'(action), 32'd0);
        pop_chk("grps_rsp", rsp_valid, rsp_data, rsp_err);
        tick();
        chk("grps_rsp_done", 32'(rsp_valid), 32'd0);
        chk("grps_ready_again", 32'(cmd_ready), 32'd1);

        // IMM held for IMM_HOLD=3 cycles.
        send(OP_IMM, 2'd2, 5'd0, 32'h0000_80A0, 1'b1, {1'b0, 32'd0});
        chk("imm_din", din, 32'h0000_80A0);
        chk("imm_mindex", 32'(mindex), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("imm_action_c%0d", i), 32'(action), 32'd9);
            chk($sformatf("imm_no_rsp_c%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("imm_action_off", 32'(action), 32'd0);
        pop_chk("imm_rsp", rsp_valid, rsp_data, rsp_err);
        tick();

        // PUSH to mindex 1 stalled 20 cycles; other flag bits must not matter.
        tx_full = 4'b0010;
        send(OP_PUSH, 2'd1, 5'd0, 32'd10, 1'b1, {1'b0, 32'd0});
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("push_stall_action_c%0d", i), 32'(action), 32'd0);
            chk($sformatf("push_stall_rsp_c%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        tx_full = 4'b1101;
        tick();
        chk("push_action", 32'(action), 32'd4);
        chk("push_din", din, 32'd10);
        chk("push_mindex", 32'(mindex), 32'd1);
        tick();
        chk("push_action_off", 32'(action), 32'd0);
        pop_chk("push_rsp", rsp_valid, rsp_data, rsp_err);
        tick();
        tx_full = 4'b0000;

        // PULL on mindex 0, FIFO not empty.
        rx_empty = 4'b1110;
        dout = 32'hDEAD_BEEF;
        send(OP_PULL, 2'd0, 5'd0, 32'd0, 1'b1, {1'b0, 32'hDEAD_BEEF});
        chk("pull_wait_action", 32'(action), 32'd0);
        tick();
        chk("pull_action", 32'(action), 32'd3);
        chk("pull_mindex", 32'(mindex), 32'd0);
        tick();
        chk("pull_capt_action", 32'(action), 32'd0);
        chk("pull_capt_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        dout = 32'h1234_5678;
        pop_chk("pull_rsp", rsp_valid, rsp_data, rsp_err);
        tick();

        // PULL timeout on the WAIT_MAX=16 instance.
        rx_empty = 4'b1111;
        chk("to_ready", 32'(cmd_ready_b), 32'd1);
        cmd_op = OP_PULL; cmd_mindex = 2'd0; cmd_index = '0; cmd_data = '0;
        cmd_valid_b = 1'b1;
        exp_q.push_back({1'b1, 32'd0});
        tick();
        cmd_valid_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_stall_action_c%0d", i), 32'(action_b), 32'd0);
            chk($sformatf("to_stall_rsp_c%0d", i), 32'(rsp_valid_b), 32'd0);
            tick();
        end
        chk("to_action", 32'(action_b), 32'd0);
        pop_chk("to_rsp", rsp_valid_b, rsp_data_b, rsp_err_b);
        tick();
        chk("to_never_issued", {din_b[29:0], index_b[1:0]} | {30'd0, mindex_b}, 32'd0);
        rx_empty = 4'b0000;

        // DIV then NONE: NONE issues nothing and leaves the bus fields alone.
        send(OP_DIV, 2'd3, 5'd0, 32'h0002_0000, 1'b1, {1'b0, 32'd0});
        chk("div_action", 32'(action), 32'd7);
        wait_rsp("div_rsp", 10);
        send(OP_NONE, 2'd1, 5'd4, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'd0});
        chk("none_action", 32'(action), 32'd0);
        chk("none_din_kept", din, 32'h0002_0000);
        chk("none_mindex_kept", 32'(mindex), 32'd3);
        pop_chk("none_rsp", rsp_valid, rsp_data, rsp_err);
        tick();

        // INSTR carries the slot index to the bus.
        send(OP_INSTR, 2'd1, 5'd17, 32'h0000_E001, 1'b1, {1'b0, 32'd0});
        chk("instr_index", 32'(index), 32'd17);
        chk("instr_action", 32'(action), 32'd1);
        wait_rsp("instr_rsp", 10);

        // Illegal op 12 with response backpressure.
        rsp_ready = 1'b0;
        send(4'd12, 2'd0, 5'd0, 32'h5555_AAAA, 1'b1, {1'b1, 32'd0});
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ill_action_c%0d", i), 32'(action), 32'd0);
            chk($sformatf("ill_cmd_ready_c%0d", i), 32'(cmd_ready), 32'd0);
            chk($sformatf("ill_rsp_stable_c%0d", i), {rsp_valid, rsp_err, rsp_data[29:0]}, 32'hC000_0000);
            tick();
        end
        rsp_ready = 1'b1;
        pop_chk("ill_rsp", rsp_valid, rsp_data, rsp_err);
        tick();
        chk("ill_rsp_done", 32'(rsp_valid), 32'd0);
        chk("ill_ready_again", 32'(cmd_ready), 32'd1);

        // Reset during the HOLD of an IMM: abandoned, no response.
        send(OP_IMM, 2'd0, 5'd0, 32'h0000_1234, 1'b0, 33'd0);
        chk("rimm_action_issue", 32'(action), 32'd9);
        tick();
        chk("rimm_action_hold", 32'(action), 32'd9);
        reset_n = 1'b0;
        #1;
        chk("rimm_action_async", 32'(action), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rimm_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rimm_no_rsp_c%0d", i), {30'd0, rsp_valid, action != 6'd0}, 32'd0);
            tick();
        end

        send(OP_EN, 2'd2, 5'd0, 32'h0000_0004, 1'b1, {1'b0, 32'd0});
        chk("en_action", 32'(action), 32'd6);
        wait_rsp("en_rsp", 10);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
